// File: rtl/lht_mp_pkg.sv
// Shared types and default geometry for the local history table.
package lht_mp_pkg;
    localparam int ASID_WIDTH     = 16;
    localparam int PC_W           = 32;
    localparam int LHT_N_SETS     = 512;
    localparam int LHT_EPB        = 8;
    localparam int LHT_LH_W       = 8;
    localparam int LHT_N_UPD      = 2;
    localparam int LHT_FIFO_DEPTH = 4;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} lht_state_e;
endpackage

// File: rtl/bram_1rport_1wport.sv
// Simple dual-port RAM: registered read (read-first on collision), byte-enabled write.
module bram_1rport_1wport #(
    parameter int DEPTH = 512,
    parameter int DW    = 64
) (
    input  logic                     clk_i,
    input  logic                     ren_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW/8-1:0]          wbe_i,
    input  logic [DW-1:0]            wdata_i
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (ren_i) rdata_o <= mem_q[raddr_i];
        if (we_i)
            for (int b = 0; b < DW/8; b++)
                if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
endmodule

// File: rtl/lht_index_hash.sv
// Set index hash: XOR-folds the PC bits above the slot field and the ASID into IDX_W bits.
module lht_index_hash #(
    parameter int IDX_W  = 9,
    parameter int PCH_W  = 28,
    parameter int ASID_W = 16
) (
    input  logic [PCH_W-1:0]  pch_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic [IDX_W-1:0]  idx_o
);
    always_comb begin
        idx_o = '0;
        for (int b = 0; b < PCH_W; b++) idx_o[b % IDX_W] = idx_o[b % IDX_W] ^ pch_i[b];
        for (int a = 0; a < ASID_W; a++) idx_o[a % IDX_W] = idx_o[a % IDX_W] ^ asid_i[a];
    end
endmodule

// File: rtl/lht_upd_fifo.sv
// Update FIFO: up to N_IN pushes per cycle packed in channel order, up to 2 pops, peek of two heads.
module lht_upd_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4,
    parameter int N_IN  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_IN-1:0]                push_i,
    input  logic [N_IN-1:0][W-1:0]         din_i,
    input  logic [1:0]                     pop_i,
    output logic [W-1:0]                   head0_o,
    output logic [W-1:0]                   head1_o,
    output logic [$clog2(DEPTH):0]         cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]                mem_q [DEPTH];
    logic [AW-1:0]               rptr_q, wptr_q;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               npush;
    logic [N_IN-1:0][AW-1:0]     wslot;

    // Each pushing channel lands after all lower-numbered pushing channels.
    always_comb begin
        npush = '0;
        wslot = '0;
        for (int c = 0; c < N_IN; c++) begin
            wslot[c] = wptr_q + AW'(npush);
            npush    = npush + CW'(push_i[c]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(npush);
            rptr_q <= rptr_q + AW'(pop_i);
            cnt_q  <= cnt_q + npush - CW'(pop_i);
            for (int c = 0; c < N_IN; c++)
                if (push_i[c]) mem_q[wslot[c]] <= din_i[c];
        end
    end

    assign head0_o = mem_q[rptr_q];
    assign head1_o = mem_q[AW'(rptr_q + 1'b1)];
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/lht_mp.sv
// Local history table: hashed {PC, ASID} sets of per-slot history, one read per cycle,
// N_UPD buffered update channels drained (with pair coalescing) into one BRAM write port.
module lht_mp import lht_mp_pkg::*; #(
    parameter int N_SETS     = LHT_N_SETS,
    parameter int EPB        = LHT_EPB,
    parameter int LH_W       = LHT_LH_W,
    parameter int N_UPD      = LHT_N_UPD,
    parameter int FIFO_DEPTH = LHT_FIFO_DEPTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        valid_REQ,
    input  logic [PC_W-1:0]             full_PC_REQ,
    input  logic [ASID_WIDTH-1:0]       ASID_REQ,
    output logic [EPB*LH_W-1:0]         lh_by_instr_RESP,
    output logic                        init_done,
    input  logic [N_UPD-1:0]            update_valid,
    input  logic [N_UPD*PC_W-1:0]       update_start_full_PC,
    input  logic [N_UPD*ASID_WIDTH-1:0] update_ASID,
    input  logic [N_UPD*LH_W-1:0]       update_lh,
    output logic                        update_ready
);
    localparam int IDX_W   = $clog2(N_SETS);
    localparam int LOG_EPB = $clog2(EPB);
    localparam int PCH_W   = PC_W - LOG_EPB - 1;
    localparam int DW      = EPB * LH_W;
    localparam int NB      = DW / 8;
    localparam int BPS     = LH_W / 8;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [LOG_EPB-1:0] slot;
        logic [LH_W-1:0]    lh;
    } lht_upd_entry_t;
    localparam int EW = $bits(lht_upd_entry_t);

    lht_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              sweep_q, sweep_d;
    logic                          ready_q, ready_d;
    logic                          rd_zero_q;
    logic [NB-1:0]                 fwd_be_q;
    logic [DW-1:0]                 fwd_data_q;

    logic [IDX_W-1:0]              req_idx;
    logic [N_UPD-1:0][EW-1:0]      upd_ent;
    logic [N_UPD-1:0]              upd_pc_lsb;
    logic [N_UPD-1:0]              acc;
    logic [CW-1:0]                 npush, cnt;
    logic [1:0]                    pop;
    lht_upd_entry_t                head0, head1;
    logic                          we;
    logic [IDX_W-1:0]              widx;
    logic [NB-1:0]                 wbe;
    logic [DW-1:0]                 wdata, rd_data;
    logic                          unused_pc_lsb;

    lht_index_hash #(.IDX_W(IDX_W), .PCH_W(PCH_W), .ASID_W(ASID_WIDTH)) u_req_hash (
        .pch_i  (full_PC_REQ[PC_W-1:LOG_EPB+1]),
        .asid_i (ASID_REQ),
        .idx_o  (req_idx)
    );

    for (genvar c = 0; c < N_UPD; c++) begin : g_upd
        logic [IDX_W-1:0] idx;
        lht_index_hash #(.IDX_W(IDX_W), .PCH_W(PCH_W), .ASID_W(ASID_WIDTH)) u_hash (
            .pch_i  (update_start_full_PC[c*PC_W+LOG_EPB+1 +: PCH_W]),
            .asid_i (update_ASID[c*ASID_WIDTH +: ASID_WIDTH]),
            .idx_o  (idx)
        );
        assign upd_ent[c]    = {idx, update_start_full_PC[c*PC_W+1 +: LOG_EPB], update_lh[c*LH_W +: LH_W]};
        assign upd_pc_lsb[c] = update_start_full_PC[c*PC_W];
    end

    assign unused_pc_lsb = ^{full_PC_REQ[0], upd_pc_lsb};

    assign acc = update_valid & {N_UPD{ready_q}};

    lht_upd_fifo #(.W(EW), .DEPTH(FIFO_DEPTH), .N_IN(N_UPD)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (acc),
        .din_i   (upd_ent),
        .pop_i   (pop),
        .head0_o (head0),
        .head1_o (head1),
        .cnt_o   (cnt)
    );

    bram_1rport_1wport #(.DEPTH(N_SETS), .DW(DW)) u_bram (
        .clk_i   (CLK),
        .ren_i   (valid_REQ),
        .raddr_i (req_idx),
        .rdata_o (rd_data),
        .we_i    (we),
        .waddr_i (widx),
        .wbe_i   (wbe),
        .wdata_i (wdata)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == S_INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == IDX_W'(N_SETS - 1)) state_d = S_RUN;
        end
    end

    // Single write port: sweep in INIT, otherwise the head (plus head+1 when it shares the set).
    // head+1 is applied last so a same-slot pair leaves the younger value.
    always_comb begin
        pop   = 2'd0;
        we    = 1'b0;
        widx  = head0.idx;
        wbe   = '0;
        wdata = '0;
        if (RST) begin
            we = 1'b0;
        end else if (state_q == S_INIT) begin
            we   = 1'b1;
            widx = sweep_q;
            wbe  = '1;
        end else if (cnt != '0) begin
            we  = 1'b1;
            pop = 2'd1;
            wbe[head0.slot*BPS +: BPS]    = '1;
            wdata[head0.slot*LH_W +: LH_W] = head0.lh;
            if (cnt >= CW'(2) && head1.idx == head0.idx) begin
                pop = 2'd2;
                wbe[head1.slot*BPS +: BPS]    = '1;
                wdata[head1.slot*LH_W +: LH_W] = head1.lh;
            end
        end
    end

    // Ready ignores this cycle's pops, so the next cycle always has room for N_UPD.
    always_comb begin
        npush = '0;
        for (int c = 0; c < N_UPD; c++) npush = npush + CW'(acc[c]);
    end
    assign ready_d = (state_d == S_RUN) && ((cnt + npush) <= CW'(FIFO_DEPTH - N_UPD));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_INIT;
            sweep_q    <= '0;
            ready_q    <= 1'b0;
            rd_zero_q  <= 1'b1;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
            if (valid_REQ) begin
                rd_zero_q  <= (state_q == S_INIT);
                fwd_be_q   <= (we && widx == req_idx) ? wbe : '0;
                fwd_data_q <= wdata;
            end
        end
    end

    always_comb begin
        lh_by_instr_RESP = '0;
        if (!rd_zero_q)
            for (int b = 0; b < NB; b++)
                lh_by_instr_RESP[b*8 +: 8] = fwd_be_q[b] ? fwd_data_q[b*8 +: 8] : rd_data[b*8 +: 8];
    end

    assign init_done    = (state_q == S_RUN);
    assign update_ready = ready_q;
endmodule

// File: tb/tb_lht_mp.sv
// Directed bench for lht_mp: init sweep, update/coalesce vectors, forwarding, backpressure, mid-run reset.
module tb_lht_mp;
    localparam int N_SETS = 512;

    logic         CLK = 1'b0;
    logic         RST;
    logic         valid_REQ;
    logic [31:0]  full_PC_REQ;
    logic [15:0]  ASID_REQ;
    logic [63:0]  lh_by_instr_RESP;
    logic         init_done;
    logic [1:0]   update_valid;
    logic [63:0]  update_start_full_PC;
    logic [31:0]  update_ASID;
    logic [15:0]  update_lh;
    logic         update_ready;

    int total = 0;
    int bad   = 0;

    lht_mp dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .valid_REQ            (valid_REQ),
        .full_PC_REQ          (full_PC_REQ),
        .ASID_REQ             (ASID_REQ),
        .lh_by_instr_RESP     (lh_by_instr_RESP),
        .init_done            (init_done),
        .update_valid         (update_valid),
        .update_start_full_PC (update_start_full_PC),
        .update_ASID          (update_ASID),
        .update_lh            (update_lh),
        .update_ready         (update_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        v0;
        logic [31:0] pc0;
        logic [7:0]  lh0;
        logic        v1;
        logic [31:0] pc1;
        logic [7:0]  lh1;
        logic [15:0] asid;
        logic [31:0] rpc;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_upd(input logic v0, input logic [31:0] pc0, input logic [7:0] lh0,
                             input logic v1, input logic [31:0] pc1, input logic [7:0] lh1,
                             input logic [15:0] asid);
        update_valid         = {v1, v0};
        update_start_full_PC = {pc1, pc0};
        update_lh            = {lh1, lh0};
        update_ASID          = {asid, asid};
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!update_ready && n < 50) begin
            step();
            n++;
        end
        if (!update_ready) check({nm, "_ready_timeout"}, 64'(update_ready), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] pc, input logic [15:0] asid, output logic [63:0] r);
        valid_REQ   = 1'b1;
        full_PC_REQ = pc;
        ASID_REQ    = asid;
        step();
        valid_REQ = 1'b0;
        r = lh_by_instr_RESP;
    endtask

    // Counts cycles with init_done low from the sample right after the reset edge.
    task automatic wait_init(input bit mid_read, output int lo, output bit rdy_seen);
        lo = 0;
        rdy_seen = 0;
        for (int i = 0; i < 2000; i++) begin
            if (init_done) break;
            if (update_ready) rdy_seen = 1;
            lo++;
            if (mid_read && i == 5) begin
                valid_REQ = 1'b1; full_PC_REQ = 32'h1000; ASID_REQ = 16'h0;
            end
            if (mid_read && i == 6) begin
                valid_REQ = 1'b0;
                check("init_read_zero", lh_by_instr_RESP, 64'h0);
            end
            step();
        end
    endtask

    logic [63:0] r;
    int          lo;
    bit          rdy_seen;
    logic [7:0]  bp_exp [12];
    int          nxt;
    bit          dropped;

    function automatic logic [31:0] bp_pc(input int k);
        return 32'h20000 + 32'(k * 16) + 32'((k % 8) * 2);
    endfunction

    initial begin
        vecs[0] = '{"single",    1, 32'h1004, 8'hA5, 0, 32'h0,    8'h00, 16'h0, 32'h1000, 64'h0000_0000_00A5_0000};
        vecs[1] = '{"coalesce",  1, 32'h2000, 8'h11, 1, 32'h2002, 8'h22, 16'h0, 32'h2000, 64'h0000_0000_0000_2211};
        vecs[2] = '{"same_slot", 1, 32'h3000, 8'h33, 1, 32'h3000, 8'h44, 16'h0, 32'h3000, 64'h0000_0000_0000_0044};
        vecs[3] = '{"ch1_only",  0, 32'h0,    8'h00, 1, 32'h400E, 8'h5C, 16'h0, 32'h4000, 64'h5C00_0000_0000_0000};
        vecs[4] = '{"merge_old", 1, 32'h1006, 8'h77, 0, 32'h0,    8'h00, 16'h0, 32'h1000, 64'h0000_0000_77A5_0000};
        vecs[5] = '{"untouched", 0, 32'h0,    8'h00, 0, 32'h0,    8'h00, 16'h0, 32'h8000, 64'h0};
        vecs[6] = '{"asid",      1, 32'h1004, 8'h99, 0, 32'h0,    8'h00, 16'h2, 32'h1000, 64'h0000_0000_0099_0000};

        RST = 1'b1; valid_REQ = 1'b0; full_PC_REQ = '0; ASID_REQ = '0;
        drive_upd(0, 0, 0, 0, 0, 0, 0);
        step();
        RST = 1'b0;
        check("rst_resp", lh_by_instr_RESP, 64'h0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_ready", 64'(update_ready), 64'd0);
        wait_init(0, lo, rdy_seen);
        check("init_cycles", 64'(lo), 64'(N_SETS));
        check("init_ready_low", 64'(rdy_seen), 64'd0);
        do_read(32'h1234, 16'h0, r);
        check("post_init_zero", r, 64'h0);

        for (int i = 0; i < 7; i++) begin
            wait_ready(vecs[i].name);
            drive_upd(vecs[i].v0, vecs[i].pc0, vecs[i].lh0, vecs[i].v1, vecs[i].pc1, vecs[i].lh1, vecs[i].asid);
            step();
            drive_upd(0, 0, 0, 0, 0, 0, 0);
            repeat (6) step();
            do_read(vecs[i].rpc, vecs[i].asid, r);
            check(vecs[i].name, r, vecs[i].exp);
        end
        repeat (3) step();
        check("resp_hold", lh_by_instr_RESP, 64'h0000_0000_0099_0000);

        // Write-first forwarding: the read lands in the cycle the drain writes slot4.
        wait_ready("fwd_a");
        drive_upd(1, 32'h6000, 8'h10, 0, 0, 0, 16'h0);
        step();
        drive_upd(0, 0, 0, 0, 0, 0, 0);
        repeat (6) step();
        wait_ready("fwd_b");
        drive_upd(1, 32'h6008, 8'hC3, 0, 0, 0, 16'h0);
        step();
        drive_upd(0, 0, 0, 0, 0, 0, 0);
        do_read(32'h6000, 16'h0, r);
        check("forward", r, 64'h0000_00C3_0000_0010);

        // Backpressure: two updates offered every cycle, each to its own set.
        for (int k = 0; k < 12; k++) bp_exp[k] = 8'h00;
        nxt = 0;
        dropped = 0;
        for (int cyc = 0; cyc < 200 && nxt < 12; cyc++) begin
            drive_upd(nxt < 12, bp_pc(nxt), 8'h80 + 8'(nxt),
                      nxt + 1 < 12, bp_pc(nxt + 1), 8'h80 + 8'(nxt + 1), 16'h0);
            if (update_ready) begin
                bp_exp[nxt] = 8'h80 + 8'(nxt);
                if (nxt + 1 < 12) bp_exp[nxt + 1] = 8'h80 + 8'(nxt + 1);
                nxt = nxt + 2;
            end else begin
                dropped = 1;
            end
            step();
        end
        drive_upd(0, 0, 0, 0, 0, 0, 0);
        check("bp_all_accepted", 64'(nxt), 64'd12);
        check("bp_ready_dropped", 64'(dropped), 64'd1);
        repeat (10) step();
        for (int k = 0; k < 12; k++) begin
            do_read(bp_pc(k) & 32'hFFFF_FFF0, 16'h0, r);
            check($sformatf("bp_read%0d", k), r, 64'(bp_exp[k]) << (8 * (k % 8)));
        end

        // Reset while the FIFO still holds updates.
        do_read(32'h1000, 16'h0, r);
        check("asid0_intact", r, 64'h0000_0000_77A5_0000);
        wait_ready("mid_a");
        drive_upd(1, 32'h7000, 8'h01, 1, 32'h9000, 8'h02, 16'h0);
        step();
        drive_upd(1, 32'h7002, 8'h03, 1, 32'h9002, 8'h04, 16'h0);
        check("mid_ready_b", 64'(update_ready), 64'd1);
        step();
        drive_upd(0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mid_rst_ready", 64'(update_ready), 64'd0);
        check("mid_rst_resp", lh_by_instr_RESP, 64'h0);
        wait_init(1, lo, rdy_seen);
        check("mid_init_cycles", 64'(lo), 64'(N_SETS));
        check("mid_init_ready_low", 64'(rdy_seen), 64'd0);
        repeat (8) step();
        do_read(32'h7000, 16'h0, r);
        check("flush_7000", r, 64'h0);
        do_read(32'h9000, 16'h0, r);
        check("flush_9000", r, 64'h0);
        do_read(32'h1000, 16'h0, r);
        check("sweep_1000", r, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
